// File: rtl/mem_arbiter_pkg.sv
// Shared types for the block-RAM arbiter.
// Holds the FSM state encoding and the port identifiers.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_V = 1'b1;

    // Counter width able to hold 0..max_wait inclusive.
    function automatic int wait_bits(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of decisions lost by the video port.
// Ports: clk, reset (async, active-low), inc, clr in; sat out.
module mem_arbiter_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = wait_bits(MAX_WAIT);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a registered-output block RAM.
// Ports: CPU port a_* (rd/wr), video port v_* (rd only),
// RAM side en/memwrite/memread/adr/writedata out, memdata in.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [RAM_ADDR_BITS-1:0] a_adr,
    input  logic [WIDTH-1:0]         a_wdata,
    output logic                     a_ack,
    output logic                     a_rvalid,
    output logic [WIDTH-1:0]         a_rdata,
    input  logic                     v_req,
    input  logic [RAM_ADDR_BITS-1:0] v_adr,
    output logic                     v_ack,
    output logic                     v_rvalid,
    output logic [WIDTH-1:0]         v_rdata,
    output logic                     en,
    output logic                     memwrite,
    output logic                     memread,
    output logic [RAM_ADDR_BITS-1:0] adr,
    output logic [WIDTH-1:0]         writedata,
    input  logic [WIDTH-1:0]         memdata
);

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     en_q, en_d;
    logic                     mw_q, mw_d;
    logic                     mr_q, mr_d;
    logic [RAM_ADDR_BITS-1:0] adr_q, adr_d;
    logic [WIDTH-1:0]         wd_q, wd_d;
    logic                     a_ack_q, a_ack_d;
    logic                     v_ack_q, v_ack_d;
    logic                     a_rv_q, a_rv_d;
    logic                     v_rv_q, v_rv_d;

    logic v_sat;
    logic wait_inc;
    logic wait_clr;
    logic grant_v;
    logic grant_a;

    mem_arbiter_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .sat   (v_sat)
    );

    // V wins outright once starved; otherwise only when A is quiet.
    assign grant_v = v_req && (v_sat || !a_req);
    assign grant_a = a_req && !grant_v;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        en_d     = 1'b0;
        mw_d     = 1'b0;
        mr_d     = 1'b0;
        adr_d    = adr_q;
        wd_d     = wd_q;
        a_ack_d  = 1'b0;
        v_ack_d  = 1'b0;
        a_rv_d   = 1'b0;
        v_rv_d   = 1'b0;
        wait_inc = 1'b0;
        wait_clr = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d  = IDLE;
                wait_clr = !v_req;
                if (grant_v) begin
                    state_d  = ISSUE;
                    owner_d  = PORT_V;
                    en_d     = 1'b1;
                    mr_d     = 1'b1;
                    adr_d    = v_adr;
                    v_ack_d  = 1'b1;
                    wait_clr = 1'b1;
                end else if (grant_a) begin
                    state_d  = ISSUE;
                    owner_d  = PORT_A;
                    en_d     = 1'b1;
                    mw_d     = a_we;
                    mr_d     = !a_we;
                    adr_d    = a_adr;
                    a_ack_d  = 1'b1;
                    wait_inc = v_req;
                    if (a_we) begin
                        wd_d = a_wdata;
                    end
                end
            end
            ISSUE: begin
                // RAM acts on this edge; reads return next cycle.
                if (mw_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                    a_rv_d  = (owner_q == PORT_A);
                    v_rv_d  = (owner_q == PORT_V);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= PORT_A;
            en_q    <= 1'b0;
            mw_q    <= 1'b0;
            mr_q    <= 1'b0;
            adr_q   <= '0;
            wd_q    <= '0;
            a_ack_q <= 1'b0;
            v_ack_q <= 1'b0;
            a_rv_q  <= 1'b0;
            v_rv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            en_q    <= en_d;
            mw_q    <= mw_d;
            mr_q    <= mr_d;
            adr_q   <= adr_d;
            wd_q    <= wd_d;
            a_ack_q <= a_ack_d;
            v_ack_q <= v_ack_d;
            a_rv_q  <= a_rv_d;
            v_rv_q  <= v_rv_d;
        end
    end

    assign en        = en_q;
    assign memwrite  = mw_q;
    assign memread   = mr_q;
    assign adr       = adr_q;
    assign writedata = wd_q;
    assign a_ack     = a_ack_q;
    assign v_ack     = v_ack_q;
    assign a_rvalid  = a_rv_q;
    assign v_rvalid  = v_rv_q;
    assign a_rdata   = memdata;
    assign v_rdata   = memdata;

endmodule
